// File: rtl/gpr_wb_arbiter.sv
// GPR writeback arbiter: ALU/load round-robin onto a single write port,
// with a pending-write scoreboard for source hazard checks.
module gpr_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_req,
  input  logic [ADDR_W-1:0]     alu_dest,
  input  logic [DATA_W-1:0]     alu_data,
  output logic                  alu_gnt,
  input  logic                  mem_req,
  input  logic [ADDR_W-1:0]     mem_dest,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  mem_gnt,
  output logic                  reg_write_en,
  output logic [ADDR_W-1:0]     reg_write_dest,
  output logic [DATA_W-1:0]     reg_write_data,
  input  logic                  issue_valid,
  input  logic [ADDR_W-1:0]     issue_dest,
  input  logic [ADDR_W-1:0]     chk_addr_1,
  input  logic [ADDR_W-1:0]     chk_addr_2,
  output logic                  hazard,
  output logic [2**ADDR_W-1:0]  pending
);

  localparam int NREG = 2**ADDR_W;

  typedef enum logic {
    ALU_FIRST = 1'b0,
    MEM_FIRST = 1'b1
  } prio_e;

  prio_e             prio_q;
  prio_e             prio_d;
  logic              contested;
  logic              any_gnt;
  logic [ADDR_W-1:0] win_dest;
  logic [DATA_W-1:0] win_data;
  logic [NREG-1:0]   pend_d;

  always_comb begin
    alu_gnt   = 1'b0;
    mem_gnt   = 1'b0;
    prio_d    = prio_q;
    win_dest  = alu_dest;
    win_data  = alu_data;
    contested = alu_req & mem_req;
    if (rst_n) begin
      unique case (1'b1)
        contested & (prio_q == ALU_FIRST): alu_gnt = 1'b1;
        contested & (prio_q == MEM_FIRST): mem_gnt = 1'b1;
        alu_req & ~mem_req:                alu_gnt = 1'b1;
        mem_req & ~alu_req:                mem_gnt = 1'b1;
        default: ;
      endcase
      // Only contested cycles move the round-robin pointer
      if (contested)
        prio_d = (prio_q == ALU_FIRST) ? MEM_FIRST : ALU_FIRST;
      if (mem_gnt) begin
        win_dest = mem_dest;
        win_data = mem_data;
      end
    end
  end

  assign any_gnt = alu_gnt | mem_gnt;

  // Set after clear so a same-index issue keeps the bit pending
  always_comb begin
    pend_d = pending;
    if (reg_write_en)
      pend_d[reg_write_dest] = 1'b0;
    if (issue_valid)
      pend_d[issue_dest] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q         <= ALU_FIRST;
      reg_write_en   <= 1'b0;
      reg_write_dest <= '0;
      reg_write_data <= '0;
      pending        <= '0;
    end else begin
      prio_q       <= prio_d;
      reg_write_en <= any_gnt;
      pending      <= pend_d;
      if (any_gnt) begin
        reg_write_dest <= win_dest;
        reg_write_data <= win_data;
      end
    end
  end

  assign hazard = pending[chk_addr_1] | pending[chk_addr_2];

endmodule
